// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read side and the UART transmitter.
// slave = transmitter side, master = FIFO / driver side.
interface fifo_uart_tx_if;
   logic       tx_en;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       rd;
   logic       tx;
   logic       busy;
   logic       frame_done;

   modport master (
      output tx_en, fifo_empty, fifo_data,
      input  rd, tx, busy, frame_done
   );

   modport slave (
      input  tx_en, fifo_empty, fifo_data,
      output rd, tx, busy, frame_done
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and serialises them as UART frames (start, 8 data LSB-first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic           clk,
   input logic           rst,
   fifo_uart_tx_if.slave bus
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;
   logic          load;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_LAST);
   // Pops happen only at a frame boundary; rd is held low while empty or in reset.
   assign load = !rst && bus.tx_en && !bus.fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_end));

   assign bus.rd         = load;
   assign bus.tx         = tx_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = (state_q == STOP) && bit_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = ((state_q == IDLE) || bit_end) ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE:  ;
         START: if (bit_end) begin
            state_d = DATA;
            idx_d   = 3'd0;
         end
         DATA: if (bit_end) begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A load overrides the STOP->IDLE exit, giving gap-free back-to-back frames.
      if (load) begin
         state_d = START;
         cnt_d   = '0;
         idx_d   = 3'd0;
         shift_d = bus.fifo_data;
`ifdef UART_TX_PARITY_EN
         par_d   = ^bus.fifo_data;
`endif
      end

      // tx is registered from the next state so the line changes exactly on bit boundaries.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO plus a frame-level line model predict tx/busy/frame_done/rd per cycle.
// A second instance with CLKS_PER_BIT=2 checks timing scaling.
module tb_fifo_uart_tx;
   localparam int CPB  = 4;
   localparam int CPB2 = 2;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   fifo_uart_tx_if bus ();
   fifo_uart_tx_if bus2 ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   fifo_uart_tx #(.CLKS_PER_BIT(CPB2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   always #5 clk = ~clk;

   // Frame as sent on the line, bit 0 first.
   function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   // Reference: FIFO contents plus the per-cycle line waveform still owed ({tx, frame_done}).
   logic [7:0] fq[$];
   logic [1:0] stream[$];
   logic       m_tx, m_busy, m_fd, m_rd;

   initial begin
      logic [1:0]    e;
      logic [NB-1:0] fb;
      m_tx = 1'b1; m_busy = 1'b0; m_fd = 1'b0; m_rd = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = 8'h00;
      forever begin
         @(negedge clk);
         bus.fifo_empty = (fq.size() == 0);
         bus.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
         #1;
         if (rst) stream.delete();
         if (stream.size() != 0) begin
            e = stream.pop_front();
            m_tx = e[1]; m_busy = 1'b1; m_fd = e[0];
         end else begin
            m_tx = 1'b1; m_busy = 1'b0; m_fd = 1'b0;
         end
         m_rd = !rst && bus.tx_en && (fq.size() != 0) && (stream.size() == 0);
         if (m_rd) begin
            fb = frame_bits(fq.pop_front());
            for (int i = 0; i < NB; i++)
               for (int c = 0; c < CPB; c++)
                  stream.push_back({fb[i], (i == NB - 1) && (c == CPB - 1)});
         end
      end
   end

   task automatic test_reset();
      @(negedge clk); #2;
      total++;
      if ({bus.tx, bus.busy, bus.rd, bus.frame_done} !== 4'b1000) begin
         bad++; $display("FAIL reset_idle: tx/busy/rd/fd=%b want 1000", {bus.tx, bus.busy, bus.rd, bus.frame_done});
      end
      @(posedge clk); #2;
      rst = 1'b0;
      fq.push_back(8'h5A);
      fq.push_back(8'hC3);
      for (int k = 0; k < 4 * CPB; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL reset_pre cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if ({bus.tx, bus.busy, bus.rd} !== 3'b100) begin
         bad++; $display("FAIL reset_async: tx/busy/rd=%b want 100", {bus.tx, bus.busy, bus.rd});
      end
      @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      for (int k = 0; k < NB * CPB + 6; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL reset_post cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
      end
   endtask

   task automatic test_single();
      int            rd_at = -1000;
      int            fd_at = -1;
      int            n_rd  = 0;
      int            off;
      logic [NB-1:0] got = '0;
      logic [NB-1:0] want;
      want = frame_bits(8'hA5);
      @(posedge clk); #2;
      fq.push_back(8'hA5);
      for (int k = 0; k < NB * CPB + 8; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL single cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (bus.rd === 1'b1) begin n_rd++; rd_at = k; end
         if (bus.frame_done === 1'b1) fd_at = k;
         off = k - rd_at - 1;
         if (off >= 0 && (off % CPB) == CPB / 2 && (off / CPB) < NB) got[off / CPB] = bus.tx;
      end
      total++;
      if (n_rd != 1) begin bad++; $display("FAIL single_rd_count: got %0d want 1", n_rd); end
      total++;
      if (fd_at - rd_at != NB * CPB) begin bad++; $display("FAIL single_frame_len: got %0d want %0d", fd_at - rd_at, NB * CPB); end
      total++;
      if (got !== want) begin bad++; $display("FAIL single_bits: got %b want %b", got, want); end
   endtask

   task automatic test_back_to_back();
      int   n_rd = 0, n_busy = 0, n_rise = 0;
      logic prev_busy = 1'b0;
      @(posedge clk); #2;
      fq.push_back(8'h00);
      fq.push_back(8'hFF);
      for (int k = 0; k < 2 * NB * CPB + 8; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL b2b cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (bus.rd === 1'b1) n_rd++;
         if (bus.busy === 1'b1) n_busy++;
         if (bus.busy === 1'b1 && prev_busy == 1'b0) n_rise++;
         prev_busy = bus.busy;
      end
      total++;
      if (n_rd != 2) begin bad++; $display("FAIL b2b_rd_count: got %0d want 2", n_rd); end
      total++;
      if (n_busy != 2 * NB * CPB || n_rise != 1) begin
         bad++; $display("FAIL b2b_busy: cycles %0d rises %0d want %0d and 1", n_busy, n_rise, 2 * NB * CPB);
      end
   endtask

   task automatic test_tx_en();
      int n_rd = 0;
      @(posedge clk); #2;
      bus.tx_en = 1'b0;
      fq.push_back(8'h3C);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL txen_off cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (bus.rd === 1'b1) n_rd++;
      end
      total++;
      if (n_rd != 0) begin bad++; $display("FAIL txen_off_rd: got %0d pops want 0", n_rd); end
      @(posedge clk); #2;
      bus.tx_en = 1'b1;
      for (int k = 0; k < NB * CPB + 4; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL txen_on cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
      end
      n_rd = 0;
      @(posedge clk); #2;
      fq.push_back(8'h11);
      fq.push_back(8'h22);
      for (int k = 0; k < 2 * NB * CPB + 8; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL txen_drop cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (bus.rd === 1'b1) n_rd++;
         if (k == 8) begin @(posedge clk); #2 bus.tx_en = 1'b0; end
      end
      total++;
      if (n_rd != 1) begin bad++; $display("FAIL txen_drop_rd: got %0d pops want 1", n_rd); end
      @(posedge clk); #2;
      fq.delete();
      bus.tx_en = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_empty();
      int n_rd = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== 4'b1000) begin
            bad++; $display("FAIL empty cyc=%0d: tx/busy/fd/rd=%b want 1000", k, {bus.tx, bus.busy, bus.frame_done, bus.rd});
         end
         if (bus.rd === 1'b1) n_rd++;
      end
      total++;
      if (n_rd != 0) begin bad++; $display("FAIL empty_rd: got %0d pops want 0", n_rd); end
   endtask

   task automatic test_parity();
      int            r1 = -1000, r2 = -1000, f1 = -1, n_rd = 0;
      logic          p1 = 1'bx, p2 = 1'bx;
      logic [NB-1:0] w1, w2;
      w1 = frame_bits(8'h07);
      w2 = frame_bits(8'h03);
      @(posedge clk); #2;
      fq.push_back(8'h07);
      fq.push_back(8'h03);
      for (int k = 0; k < 2 * NB * CPB + 8; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL parity cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (bus.rd === 1'b1) begin
            n_rd++;
            if (n_rd == 1) r1 = k; else r2 = k;
         end
         if (bus.frame_done === 1'b1 && f1 < 0) f1 = k;
         if (k == r1 + 1 + 9 * CPB + CPB / 2) p1 = bus.tx;
         if (k == r2 + 1 + 9 * CPB + CPB / 2) p2 = bus.tx;
      end
      total++;
      if (p1 !== w1[9] || p2 !== w2[9]) begin
         bad++; $display("FAIL parity_bit: got %b/%b want %b/%b", p1, p2, w1[9], w2[9]);
      end
      total++;
      if (f1 - r1 != NB * CPB) begin bad++; $display("FAIL parity_frame_len: got %0d want %0d", f1 - r1, NB * CPB); end
   endtask

   task automatic test_random();
      int gap;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         fq.push_back(8'($urandom));
         bus.tx_en = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(1, 40);
         for (int k = 0; k < gap; k++) begin
            @(negedge clk); #2;
            total++;
            if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
               bad++; $display("FAIL random i=%0d cyc=%0d: tx/busy/fd/rd=%b want %b", i, k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
            end
         end
      end
      @(posedge clk); #2;
      bus.tx_en = 1'b1;
      for (int k = 0; k < 10 * NB * CPB; k++) begin
         @(negedge clk); #2;
         total++;
         if ({bus.tx, bus.busy, bus.frame_done, bus.rd} !== {m_tx, m_busy, m_fd, m_rd}) begin
            bad++; $display("FAIL random_drain cyc=%0d: tx/busy/fd/rd=%b want %b", k, {bus.tx, bus.busy, bus.frame_done, bus.rd}, {m_tx, m_busy, m_fd, m_rd});
         end
         if (k > 2 && !m_busy && fq.size() == 0) break;
      end
      total++;
      if (fq.size() != 0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL random_timeout: %0d bytes left, busy=%b want 0 and 0", fq.size(), bus.busy);
      end
   endtask

   task automatic test_cpb2();
      logic [NB-1:0] fb;
      logic [2:0]    want;
      fb = frame_bits(8'hA5);
      @(posedge clk); #2;
      bus2.fifo_data  = 8'hA5;
      bus2.fifo_empty = 1'b0;
      #1;
      total++;
      if (bus2.rd !== 1'b1) begin bad++; $display("FAIL cpb2_rd: got %b want 1", bus2.rd); end
      @(posedge clk); #2;
      bus2.fifo_empty = 1'b1;
      for (int k = 0; k <= NB * CPB2; k++) begin
         if (k < NB * CPB2) begin
            @(negedge clk);
         end else begin
            @(negedge clk);
         end
         #2;
         want = (k < NB * CPB2) ? {fb[k / CPB2], 1'b1, k == NB * CPB2 - 1} : 3'b100;
         total++;
         if ({bus2.tx, bus2.busy, bus2.frame_done} !== want || bus2.rd !== 1'b0) begin
            bad++; $display("FAIL cpb2 cyc=%0d: tx/busy/fd=%b rd=%b want %b rd=0", k, {bus2.tx, bus2.busy, bus2.frame_done}, bus2.rd, want);
         end
      end
   endtask

   initial begin
      bus.tx_en       = 1'b1;
      bus2.tx_en      = 1'b1;
      bus2.fifo_empty = 1'b1;
      bus2.fifo_data  = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_tx_en();
      test_empty();
      test_parity();
      test_random();
      test_cpb2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
